// File: rtl/alu_operand_loader_if.sv
// Bus bundle between a front panel (switches, buttons) and the operand loader.
// The master drives the switch and button inputs; the slave returns the captured operands and status.
interface alu_operand_loader_if #(
  parameter int WIDTH = 6
);
  logic [WIDTH-1:0] sw;
  logic             load;
  logic             clear;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       fxn_code;
  logic             op_valid;
  logic             done;
  logic [1:0]       stage;
  logic [3:0]       op_count;

  modport master (
    output sw, load, clear,
    input  a, b, fxn_code, op_valid, done, stage, op_count
  );

  modport slave (
    input  sw, load, clear,
    output a, b, fxn_code, op_valid, done, stage, op_count
  );
endinterface

// File: rtl/alu_operand_loader.sv
// Captures operand A, operand B and a 3-bit function code from a switch bus,
// one per rising edge of the load button, and flags when a complete set is held.
module alu_operand_loader #(
  parameter int WIDTH = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  alu_operand_loader_if.slave  bus
);
  typedef enum logic [1:0] {
    LOAD_A   = 2'd0,
    LOAD_B   = 2'd1,
    LOAD_FXN = 2'd2,
    READY    = 2'd3
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [2:0]       r_fxn;
  logic             r_load_q;
  logic             r_op_valid;
  logic             r_done;
  logic [3:0]       r_op_count;
  logic             w_load_edge;

  assign w_load_edge = bus.load & ~r_load_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= LOAD_A;
      r_a        <= '0;
      r_b        <= '0;
      r_fxn      <= '0;
      r_op_valid <= 1'b0;
      r_done     <= 1'b0;
      r_op_count <= '0;
      // Start as if the button were already down, so a press held through reset is ignored.
      r_load_q   <= 1'b1;
    end else begin
      r_load_q <= bus.load;
      r_done   <= 1'b0;
      if (bus.clear) begin
        r_state    <= LOAD_A;
        r_op_valid <= 1'b0;
      end else if (w_load_edge) begin
        case (r_state)
          LOAD_A: begin
            r_a     <= bus.sw;
            r_state <= LOAD_B;
          end
          LOAD_B: begin
            r_b     <= bus.sw;
            r_state <= LOAD_FXN;
          end
          LOAD_FXN: begin
            r_fxn      <= bus.sw[2:0];
            r_state    <= READY;
            r_op_valid <= 1'b1;
            r_done     <= 1'b1;
            r_op_count <= r_op_count + 4'd1;
          end
          READY: begin
            r_a        <= bus.sw;
            r_state    <= LOAD_B;
            r_op_valid <= 1'b0;
          end
          default: begin
            r_state    <= LOAD_A;
            r_op_valid <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.a        = r_a;
  assign bus.b        = r_b;
  assign bus.fxn_code = r_fxn;
  assign bus.op_valid = r_op_valid;
  assign bus.done     = r_done;
  assign bus.stage    = r_state;
  assign bus.op_count = r_op_count;
endmodule

// File: tb/tb_alu_operand_loader.sv
// Self-checking bench for alu_operand_loader: directed scenarios plus a randomized
// run, all compared against a slot-filling reference model of the operand entry.
module tb_alu_operand_loader;
  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail = 0;

  alu_operand_loader_if #(.WIDTH(6)) bus ();

  alu_operand_loader #(.WIDTH(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: number of slots filled (0..3), the three captured values,
  // the previous button level, and the status outputs.
  int         m_filled;
  logic [5:0] m_ops [3];
  logic       m_prev_load;
  logic       m_valid;
  logic       m_done;
  int         m_count;

  task automatic cycle(input logic [5:0] s, input logic l, input logic c, input logic r);
    bit pressed;
    int slot;
    bus.sw    = s;
    bus.load  = l;
    bus.clear = c;
    reset     = r;
    @(posedge clk);
    pressed = (l == 1'b1) && (m_prev_load == 1'b0);
    if (r) begin
      m_filled    = 0;
      m_ops[0]    = '0;
      m_ops[1]    = '0;
      m_ops[2]    = '0;
      m_valid     = 1'b0;
      m_done      = 1'b0;
      m_count     = 0;
      m_prev_load = 1'b1;
    end else begin
      m_prev_load = l;
      m_done      = 1'b0;
      if (c) begin
        m_filled = 0;
        m_valid  = 1'b0;
      end else if (pressed) begin
        // A complete set is overwritten starting again from operand A.
        slot = (m_filled == 3) ? 0 : m_filled;
        m_ops[slot] = (slot == 2) ? {3'b000, s[2:0]} : s;
        m_filled = slot + 1;
        m_valid  = (m_filled == 3);
        if (m_filled == 3) begin
          m_done  = 1'b1;
          m_count = (m_count + 1) % 16;
        end
      end
    end
    #1;
    if (r || c || pressed)
      $display("txn: reset=%0b clear=%0b press=%0b sw=%b -> stage=%0d a=%b b=%b fxn=%b valid=%0b done=%0b count=%0d",
               r, c, pressed, s, bus.stage, bus.a, bus.b, bus.fxn_code, bus.op_valid, bus.done, bus.op_count);
  endtask

  // One button press: rising edge then release.
  task automatic press(input logic [5:0] s);
    cycle(s, 1'b1, 1'b0, 1'b0);
    cycle(s, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset;
    cycle(6'h3f, 1'b0, 1'b0, 1'b1);
    cycle(6'h3f, 1'b0, 1'b0, 1'b1);
    n_checks++; if (bus.stage !== 2'd0) begin n_fail++; $display("FAIL reset_stage got %0d want 0", bus.stage); end
    n_checks++; if (bus.a !== 6'd0) begin n_fail++; $display("FAIL reset_a got %b want 000000", bus.a); end
    n_checks++; if (bus.b !== 6'd0) begin n_fail++; $display("FAIL reset_b got %b want 000000", bus.b); end
    n_checks++; if (bus.fxn_code !== 3'd0) begin n_fail++; $display("FAIL reset_fxn got %b want 000", bus.fxn_code); end
    n_checks++; if (bus.op_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", bus.op_valid); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", bus.done); end
    n_checks++; if (bus.op_count !== 4'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", bus.op_count); end
    cycle(6'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_basic_set;
    press(6'b000111);
    n_checks++; if (bus.stage !== 2'd1) begin n_fail++; $display("FAIL basic_stage_b got %0d want 1", bus.stage); end
    press(6'b011000);
    n_checks++; if (bus.stage !== 2'd2) begin n_fail++; $display("FAIL basic_stage_fxn got %0d want 2", bus.stage); end
    cycle(6'b000010, 1'b1, 1'b0, 1'b0);
    n_checks++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL basic_done got %b want 1", bus.done); end
    n_checks++; if (bus.op_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got %b want 1", bus.op_valid); end
    cycle(6'b000010, 1'b0, 1'b0, 1'b0);
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse got %b want 0", bus.done); end
    n_checks++; if (bus.a !== 6'b000111) begin n_fail++; $display("FAIL basic_a got %b want 000111", bus.a); end
    n_checks++; if (bus.b !== 6'b011000) begin n_fail++; $display("FAIL basic_b got %b want 011000", bus.b); end
    n_checks++; if (bus.fxn_code !== 3'b010) begin n_fail++; $display("FAIL basic_fxn got %b want 010", bus.fxn_code); end
    n_checks++; if (bus.op_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid_hold got %b want 1", bus.op_valid); end
    n_checks++; if (bus.stage !== 2'd3) begin n_fail++; $display("FAIL basic_stage_ready got %0d want 3", bus.stage); end
    n_checks++; if (bus.op_count !== 4'd1) begin n_fail++; $display("FAIL basic_count got %0d want 1", bus.op_count); end
  endtask

  task automatic test_held_button;
    cycle(6'h00, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cycle(6'b101010, 1'b1, 1'b0, 1'b0);
      n_checks++; if (bus.stage !== m_filled[1:0]) begin n_fail++; $display("FAIL held_stage[%0d] got %0d want %0d", i, bus.stage, m_filled); end
    end
    n_checks++; if (bus.a !== 6'b101010) begin n_fail++; $display("FAIL held_a got %b want 101010", bus.a); end
    n_checks++; if (bus.stage !== 2'd1) begin n_fail++; $display("FAIL held_stage_final got %0d want 1", bus.stage); end
    cycle(6'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_clear_priority;
    logic [2:0] fxn_before;
    int         count_before;
    press(6'b001100);
    n_checks++; if (bus.stage !== 2'd2) begin n_fail++; $display("FAIL clr_setup_stage got %0d want 2", bus.stage); end
    fxn_before   = m_ops[2][2:0];
    count_before = m_count;
    cycle(6'b000101, 1'b1, 1'b1, 1'b0);
    n_checks++; if (bus.stage !== 2'd0) begin n_fail++; $display("FAIL clr_stage got %0d want 0", bus.stage); end
    n_checks++; if (bus.fxn_code !== fxn_before) begin n_fail++; $display("FAIL clr_fxn got %b want %b", bus.fxn_code, fxn_before); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL clr_done got %b want 0", bus.done); end
    n_checks++; if (bus.op_count !== 4'(count_before)) begin n_fail++; $display("FAIL clr_count got %0d want %0d", bus.op_count, count_before); end
    // Button still high after the clear: no new capture until released.
    cycle(6'b000101, 1'b1, 1'b0, 1'b0);
    n_checks++; if (bus.stage !== 2'd0) begin n_fail++; $display("FAIL clr_no_recapture got %0d want 0", bus.stage); end
    cycle(6'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_count_wrap;
    int done_seen = 0;
    cycle(6'h00, 1'b0, 1'b0, 1'b1);
    cycle(6'h00, 1'b0, 1'b0, 1'b0);
    for (int set = 1; set <= 16; set++) begin
      for (int k = 0; k < 3; k++) begin
        cycle(6'($urandom_range(0, 63)), 1'b1, 1'b0, 1'b0);
        if (bus.done === 1'b1) done_seen++;
        cycle(6'($urandom_range(0, 63)), 1'b0, 1'b0, 1'b0);
        if (bus.done === 1'b1) done_seen++;
      end
      n_checks++; if (bus.op_count !== 4'(set % 16)) begin n_fail++; $display("FAIL wrap_count[%0d] got %0d want %0d", set, bus.op_count, set % 16); end
      n_checks++; if (bus.a !== m_ops[0] || bus.b !== m_ops[1] || bus.fxn_code !== m_ops[2][2:0]) begin
        n_fail++; $display("FAIL wrap_ops[%0d] got a=%b b=%b f=%b want a=%b b=%b f=%b", set, bus.a, bus.b, bus.fxn_code, m_ops[0], m_ops[1], m_ops[2][2:0]);
      end
    end
    n_checks++; if (done_seen != 16) begin n_fail++; $display("FAIL wrap_done_pulses got %0d want 16", done_seen); end
  endtask

  task automatic test_load_through_reset;
    cycle(6'b111111, 1'b1, 1'b0, 1'b1);
    cycle(6'b111111, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(6'b111111, 1'b1, 1'b0, 1'b0);
    n_checks++; if (bus.a !== 6'd0) begin n_fail++; $display("FAIL rst_held_a got %b want 000000", bus.a); end
    n_checks++; if (bus.stage !== 2'd0) begin n_fail++; $display("FAIL rst_held_stage got %0d want 0", bus.stage); end
    cycle(6'b111111, 1'b0, 1'b0, 1'b0);
    press(6'b111111);
    n_checks++; if (bus.a !== 6'b111111) begin n_fail++; $display("FAIL rst_repress_a got %b want 111111", bus.a); end
    n_checks++; if (bus.stage !== 2'd1) begin n_fail++; $display("FAIL rst_repress_stage got %0d want 1", bus.stage); end
  endtask

  task automatic test_ready_reload;
    logic [5:0] b_old;
    logic [2:0] f_old;
    press(6'b110011);
    press(6'b010101);
    n_checks++; if (bus.op_valid !== 1'b1) begin n_fail++; $display("FAIL reload_setup_valid got %b want 1", bus.op_valid); end
    b_old = 6'b110011;
    f_old = 3'b101;
    cycle(6'b000001, 1'b1, 1'b0, 1'b0);
    n_checks++; if (bus.a !== 6'b000001) begin n_fail++; $display("FAIL reload_a got %b want 000001", bus.a); end
    n_checks++; if (bus.op_valid !== 1'b0) begin n_fail++; $display("FAIL reload_valid got %b want 0", bus.op_valid); end
    n_checks++; if (bus.stage !== 2'd1) begin n_fail++; $display("FAIL reload_stage got %0d want 1", bus.stage); end
    n_checks++; if (bus.b !== b_old) begin n_fail++; $display("FAIL reload_b got %b want %b", bus.b, b_old); end
    n_checks++; if (bus.fxn_code !== f_old) begin n_fail++; $display("FAIL reload_fxn got %b want %b", bus.fxn_code, f_old); end
    cycle(6'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random;
    logic l, c, r;
    for (int i = 0; i < 400; i++) begin
      l = ($urandom_range(0, 99) < 45);
      c = ($urandom_range(0, 99) < 6);
      r = ($urandom_range(0, 99) < 3);
      cycle(6'($urandom_range(0, 63)), l, c, r);
      n_checks++;
      if (bus.stage !== m_filled[1:0] || bus.a !== m_ops[0] || bus.b !== m_ops[1] ||
          bus.fxn_code !== m_ops[2][2:0] || bus.op_valid !== m_valid || bus.done !== m_done ||
          bus.op_count !== 4'(m_count)) begin
        n_fail++;
        $display("FAIL random[%0d] got st=%0d a=%b b=%b f=%b v=%b d=%b n=%0d want st=%0d a=%b b=%b f=%b v=%b d=%b n=%0d",
                 i, bus.stage, bus.a, bus.b, bus.fxn_code, bus.op_valid, bus.done, bus.op_count,
                 m_filled, m_ops[0], m_ops[1], m_ops[2][2:0], m_valid, m_done, m_count);
      end
    end
  endtask

  initial begin
    bus.sw      = '0;
    bus.load    = 1'b0;
    bus.clear   = 1'b0;
    reset       = 1'b1;
    m_filled    = 0;
    m_ops[0]    = '0;
    m_ops[1]    = '0;
    m_ops[2]    = '0;
    m_prev_load = 1'b1;
    m_valid     = 1'b0;
    m_done      = 1'b0;
    m_count     = 0;
    test_reset();
    test_basic_set();
    test_held_button();
    test_clear_priority();
    test_count_wrap();
    test_load_through_reset();
    test_ready_reload();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_operand_loader.md
ALU_OPERAND_LOADER -- requirements
Module: alu_operand_loader

Interface
REQ-001 Parameter WIDTH, default 6, operand width in bits; the fxn_code width is fixed at 3.
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 sw  input  WIDTH  switch bus carrying the value to capture.
REQ-005 load  input  1  load button, level, synchronous to clk; acts on its rising edge only.
REQ-006 clear  input  1  synchronous abort of the current entry.
REQ-007 a  output  WIDTH  registered operand A; drives the output mux a input.
REQ-008 b  output  WIDTH  registered operand B; drives the output mux b input.
REQ-009 fxn_code  output  3  registered function select; drives the output mux fxn_code input.
REQ-010 op_valid  output  1  high while a complete operand set is held (state READY).
REQ-011 done  output  1  one-cycle pulse when an operand set completes.
REQ-012 stage  output  2  current state encoding, for LED display.
REQ-013 op_count  output  4  number of completed operand sets, modulo 16.

Function
REQ-014 The FSM SHALL have four states, encoded on stage as LOAD_A=0, LOAD_B=1, LOAD_FXN=2 and READY=3.
REQ-015 The block SHALL register load into load_q every cycle; a load edge SHALL be defined as load=1 and load_q=0 at the same rising clk.
REQ-016 Load edges SHALL act as follows, each at the same clk edge, with zero-cycle latency from the detected edge:
  - LOAD_A: a<=sw, go to LOAD_B.
  - LOAD_B: b<=sw, go to LOAD_FXN.
  - LOAD_FXN: fxn_code<=sw[2:0], with sw[WIDTH-1:3] ignored; go to READY.
  - READY: a<=sw, go to LOAD_B.
REQ-017 Without a load edge, state, a, b, fxn_code and op_count SHALL hold; a button held high SHALL produce exactly one capture.
REQ-018 The LOAD_FXN->READY transition SHALL set done=1 for exactly the following cycle and SHALL increment op_count, wrapping 15->0.
REQ-019 op_valid SHALL be registered and equal to (stage==READY); it SHALL drop in the cycle after a READY load edge.
REQ-020 clear=1 SHALL force the state to LOAD_A at the next clk edge, from any state; a, b, fxn_code and op_count SHALL hold.
REQ-021 When clear and a load edge occur in the same cycle, clear SHALL take priority, no register SHALL be captured, and done SHALL stay 0.
REQ-022 While the block is in LOAD_B or LOAD_FXN, the outputs a, b and fxn_code SHALL show their most recently captured values; downstream logic SHALL qualify them with op_valid.

Reset
REQ-023 reset=1 at a clk edge SHALL set stage=LOAD_A, a=0, b=0, fxn_code=0, op_valid=0, done=0 and op_count=0; reset SHALL override clear and load.
REQ-024 Reset SHALL set load_q=1, so that a button held through reset produces no capture until it is released and pressed again.
REQ-025 Reset asserted mid-entry SHALL discard the partial entry with no done pulse.

Verification
REQ-026 Sequence: reset; then load edges with sw=000111, then 011000, then 000010 -> a=000111, b=011000, fxn_code=010, op_valid=1, one done pulse, op_count=1.
REQ-027 Hold load high for 10 cycles in LOAD_A with sw=101010 -> a=101010 is captured once, and stage=LOAD_B, not LOAD_FXN.
REQ-028 Apply clear in LOAD_FXN together with a load edge -> stage=LOAD_A next cycle, fxn_code unchanged, done=0, op_count unchanged.
REQ-029 Complete 16 operand sets -> op_count goes 15->0 on the 16th set, and done pulses 16 times.
REQ-030 Hold load high across the release of reset -> no capture; after release and a new press with sw=111111 -> a=111111.
REQ-031 In READY, apply a load edge with sw=000001 -> a=000001, op_valid=0 the next cycle, stage=LOAD_B, and b and fxn_code retain their old values.
